// File: rtl/vga_timing_gen_pkg.sv
// Shared SVGA 800x600@60 raster constants and the coordinate/output types used by
// the timing generator and every downstream pixel-colour stage.
package vga_pkg;

   localparam int H_VIS   = 800;
   localparam int H_FP    = 40;
   localparam int H_SYNC  = 128;
   localparam int H_BP    = 88;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 600;
   localparam int V_FP    = 1;
   localparam int V_SYNC  = 4;
   localparam int V_BP    = 23;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_VIS + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_VIS + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int H_CNT_W = 11;
   localparam int V_CNT_W = 10;

   typedef logic [9:0] coord_t;

   typedef struct packed {
      coord_t row;
      coord_t col;
      logic   blank;
      logic   hsync;
      logic   vsync;
      logic   frame_start;
      logic   line_end;
   } vga_out_t;

   typedef struct packed {
      logic [H_CNT_W-1:0] h_cnt;
      logic [V_CNT_W-1:0] v_cnt;
      logic               h_wrap;
      logic               v_wrap;
   } vga_dbg_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the pixel-colour stages and VGA port.
// Outputs change only on pix_en strobes; frame_start/line_end are one-clock pulses.
interface vga_timing_gen_if;
   import vga_pkg::*;

   coord_t row;
   coord_t col;
   logic   blank;
   logic   hsync;
   logic   vsync;
   logic   frame_start;
   logic   line_end;

   modport master (output row, col, blank, hsync, vsync, frame_start, line_end);
   modport slave  (input  row, col, blank, hsync, vsync, frame_start, line_end);

endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Enable-gated modulo counter: counts 0..MAX and wraps; wrap_o flags the MAX value.
module mod_counter #(
   parameter int WIDTH = 11,
   parameter int MAX   = 1055
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign wrap_o = (cnt_q == WIDTH'(MAX));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v position counters plus one registered output stage
// so row/col/blank/syncs/pulses all leave on the same pix_en edge.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   HVIS     = H_VIS,
   parameter int   HFP      = H_FP,
   parameter int   HSYNC    = H_SYNC,
   parameter int   HBP      = H_BP,
   parameter int   VVIS     = V_VIS,
   parameter int   VFP      = V_FP,
   parameter int   VSYNC    = V_SYNC,
   parameter int   VBP      = V_BP,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pix_en_i,
   vga_timing_gen_if.master vga_o,
   output vga_dbg_t         dbg_o
);

   localparam int HTOTAL = HVIS + HFP + HSYNC + HBP;
   localparam int VTOTAL = VVIS + VFP + VSYNC + VBP;

   localparam logic [H_CNT_W-1:0] HVIS_C     = H_CNT_W'(HVIS);
   localparam logic [H_CNT_W-1:0] HS_START_C = H_CNT_W'(HVIS + HFP);
   localparam logic [H_CNT_W-1:0] HS_END_C   = H_CNT_W'(HVIS + HFP + HSYNC);
   localparam logic [V_CNT_W-1:0] VVIS_C     = V_CNT_W'(VVIS);
   localparam logic [V_CNT_W-1:0] VS_START_C = V_CNT_W'(VVIS + VFP);
   localparam logic [V_CNT_W-1:0] VS_END_C   = V_CNT_W'(VVIS + VFP + VSYNC);

   localparam vga_out_t OUT_RST = '{
      row:         '0,
      col:         '0,
      blank:       1'b1,
      hsync:       ~SYNC_POL,
      vsync:       ~SYNC_POL,
      frame_start: 1'b0,
      line_end:    1'b0
   };

   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic               h_wrap;
   logic               v_wrap;
   logic               active;
   vga_out_t           out_q, out_d;

   mod_counter #(.WIDTH(H_CNT_W), .MAX(HTOTAL - 1)) u_h_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (pix_en_i),
      .cnt_o  (h_cnt),
      .wrap_o (h_wrap)
   );

   // The line counter steps only on the strobe that takes h_cnt from its last value to 0.
   mod_counter #(.WIDTH(V_CNT_W), .MAX(VTOTAL - 1)) u_v_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (h_wrap & pix_en_i),
      .cnt_o  (v_cnt),
      .wrap_o (v_wrap)
   );

   assign active = (h_cnt < HVIS_C) && (v_cnt < VVIS_C);

   always_comb begin
      out_d             = out_q;
      out_d.frame_start = 1'b0;
      out_d.line_end    = 1'b0;
      if (pix_en_i) begin
         out_d.blank       = ~active;
         out_d.col         = active ? h_cnt[9:0] : '0;
         out_d.row         = active ? v_cnt : '0;
         out_d.hsync       = ((h_cnt >= HS_START_C) && (h_cnt < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
         out_d.vsync       = ((v_cnt >= VS_START_C) && (v_cnt < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
         out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
         out_d.line_end    = h_wrap;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q <= OUT_RST;
      end else begin
         out_q <= out_d;
      end
   end

   assign vga_o.row         = out_q.row;
   assign vga_o.col         = out_q.col;
   assign vga_o.blank       = out_q.blank;
   assign vga_o.hsync       = out_q.hsync;
   assign vga_o.vsync       = out_q.vsync;
   assign vga_o.frame_start = out_q.frame_start;
   assign vga_o.line_end    = out_q.line_end;

   assign dbg_o = '{h_cnt: h_cnt, v_cnt: v_cnt, h_wrap: h_wrap, v_wrap: v_wrap};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size SVGA instance (positive syncs) and a shrunken
// geometry instance (negative syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int W = $bits(vga_out_t);

  localparam int S_HVIS = 16, S_HFP = 2, S_HSYNC = 3, S_HBP = 3;
  localparam int S_VVIS = 8,  S_VFP = 1, S_VSYNC = 2, S_VBP = 3;
  localparam int S_HTOT = S_HVIS + S_HFP + S_HSYNC + S_HBP;
  localparam int S_VTOT = S_VVIS + S_VFP + S_VSYNC + S_VBP;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f, rst_s, pe_f, pe_s;
  vga_dbg_t dbg_f, dbg_s;

  vga_timing_gen_if vga_f ();
  vga_timing_gen_if vga_s ();

  vga_timing_gen u_dut_full (
    .clk_i    (clk),
    .rst_ni   (rst_f),
    .pix_en_i (pe_f),
    .vga_o    (vga_f),
    .dbg_o    (dbg_f)
  );

  vga_timing_gen #(
    .HVIS(S_HVIS), .HFP(S_HFP), .HSYNC(S_HSYNC), .HBP(S_HBP),
    .VVIS(S_VVIS), .VFP(S_VFP), .VSYNC(S_VSYNC), .VBP(S_VBP),
    .SYNC_POL(1'b0)
  ) u_dut_small (
    .clk_i    (clk),
    .rst_ni   (rst_s),
    .pix_en_i (pe_s),
    .vga_o    (vga_s),
    .dbg_o    (dbg_s)
  );

  vga_out_t obs_f, obs_s;
  assign obs_f = {vga_f.row, vga_f.col, vga_f.blank, vga_f.hsync, vga_f.vsync,
                  vga_f.frame_start, vga_f.line_end};
  assign obs_s = {vga_s.row, vga_s.col, vga_s.blank, vga_s.hsync, vga_s.vsync,
                  vga_s.frame_start, vga_s.line_end};

  // scoreboard
  logic [W-1:0] exp_q_f[$];
  logic [W-1:0] exp_q_s[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int fh, fv, sh, sv;
  vga_out_t ef, es;

  function automatic vga_out_t rst_val(input logic pol);
    vga_out_t o;
    o = '0;
    o.blank = 1'b1;
    o.hsync = ~pol;
    o.vsync = ~pol;
    return o;
  endfunction

  function automatic vga_out_t model(input int h, input int v, input int hvis, input int hss,
                                     input int hse, input int htot, input int vvis,
                                     input int vss, input int vse, input logic pol);
    vga_out_t o;
    logic act;
    act = (h < hvis) && (v < vvis);
    o.blank = ~act;
    o.col = act ? coord_t'(h) : '0;
    o.row = act ? coord_t'(v) : '0;
    o.hsync = (h >= hss && h < hse) ? pol : ~pol;
    o.vsync = (v >= vss && v < vse) ? pol : ~pol;
    o.frame_start = (h == 0) && (v == 0);
    o.line_end = (h == htot - 1);
    return o;
  endfunction

  task automatic adv(inout int h, inout int v, input int htot, input int vtot);
    if (h == htot - 1) begin
      h = 0;
      v = (v == vtot - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  // driver: one clock, expected values pushed before the edge, compared after it
  task automatic step(input logic f_en, input logic s_en);
    pe_f = f_en;
    pe_s = s_en;
    if (!rst_f) begin
      ef = rst_val(1'b1); fh = 0; fv = 0;
    end else if (f_en) begin
      ef = model(fh, fv, H_VIS, H_SYNC_START, H_SYNC_END, H_TOTAL,
                 V_VIS, V_SYNC_START, V_SYNC_END, 1'b1);
      adv(fh, fv, H_TOTAL, V_TOTAL);
    end else begin
      ef.frame_start = 1'b0; ef.line_end = 1'b0;
    end
    if (!rst_s) begin
      es = rst_val(1'b0); sh = 0; sv = 0;
    end else if (s_en) begin
      es = model(sh, sv, S_HVIS, S_HVIS + S_HFP, S_HVIS + S_HFP + S_HSYNC, S_HTOT,
                 S_VVIS, S_VVIS + S_VFP, S_VVIS + S_VFP + S_VSYNC, 1'b0);
      adv(sh, sv, S_HTOT, S_VTOT);
    end else begin
      es.frame_start = 1'b0; es.line_end = 1'b0;
    end
    exp_q_f.push_back(ef);
    exp_q_s.push_back(es);
    @(posedge clk);
    #1;
    chk("sb_full", obs_f, exp_q_f.pop_front());
    chk("sb_small", obs_s, exp_q_s.pop_front());
  endtask

  initial begin
    int vis, hs, hs_rise, blank_rise, le, le_i, col_max;
    int s_fs, s_fs_last, s_vs, s_vs_start, s_hs, s_vis, s_row_max, s_le;
    int fs_a, fs_b, le_a, le_b, fs_dbl, le_dbl, held_bad, k;
    vga_out_t prev_s, a, b;

    rst_f = 1'b0; rst_s = 1'b0; pe_f = 1'b0; pe_s = 1'b0;
    fh = 0; fv = 0; sh = 0; sv = 0;
    ef = rst_val(1'b1); es = rst_val(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_full", obs_f, rst_val(1'b1));
    chk("reset_small", obs_s, rst_val(1'b0));
    chk_int("reset_hcnt", int'(dbg_f.h_cnt), 0);
    chk_int("reset_vcnt", int'(dbg_s.v_cnt), 0);
    rst_f = 1'b1; rst_s = 1'b1;

    // no strobe after release: reset values must hold
    step(1'b0, 1'b0);

    // line 0 scan (full) and three-plus frames (small), pix_en = 1
    vis = 0; hs = 0; hs_rise = -1; blank_rise = -1; le = 0; le_i = -1; col_max = 0;
    s_fs = 0; s_fs_last = -1; s_vs = 0; s_vs_start = -1; s_hs = 0; s_vis = 0;
    s_row_max = 0; s_le = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      step(1'b1, 1'b1);
      if (i == 0) begin
        chk_int("first_frame_start", int'(vga_f.frame_start), 1);
        chk_int("first_blank", int'(vga_f.blank), 0);
      end
      if (!vga_f.blank) vis++;
      if (vga_f.hsync) hs++;
      if (vga_f.blank && blank_rise < 0) blank_rise = i;
      if (vga_f.hsync && hs_rise < 0) hs_rise = i;
      if (vga_f.line_end) begin le++; le_i = i; end
      if (int'(vga_f.col) > col_max) col_max = int'(vga_f.col);
      if (vga_s.frame_start) begin s_fs++; s_fs_last = i; end
      if (vga_s.line_end) s_le++;
      if (int'(vga_s.row) > s_row_max) s_row_max = int'(vga_s.row);
      if (i < S_HTOT * S_VTOT) begin
        if (!vga_s.vsync) s_vs++;
        if (!vga_s.vsync && s_vs_start < 0) s_vs_start = i;
        if (!vga_s.hsync) s_hs++;
        if (!vga_s.blank) s_vis++;
      end
    end
    chk_int("line_visible", vis, H_VIS);
    chk_int("blank_rise", blank_rise, H_VIS);
    chk_int("col_max", col_max, H_VIS - 1);
    chk_int("hsync_width", hs, H_SYNC);
    chk_int("hsync_after_blank", hs_rise - blank_rise, H_FP);
    chk_int("line_end_count", le, 1);
    chk_int("line_end_pos", le_i, H_TOTAL - 1);
    chk_int("s_frame_count", s_fs, 4);
    chk_int("s_frame_period", s_fs_last, 3 * S_HTOT * S_VTOT);
    chk_int("s_line_end_count", s_le, H_TOTAL / S_HTOT);
    chk_int("s_row_max", s_row_max, S_VVIS - 1);
    chk_int("s_visible_px", s_vis, S_HVIS * S_VVIS);
    chk_int("s_vsync_width", s_vs, S_VSYNC * S_HTOT);
    chk_int("s_vsync_start", s_vs_start, (S_VVIS + S_VFP) * S_HTOT);
    chk_int("s_hsync_cycles", s_hs, S_HSYNC * S_VTOT);

    // small instance on a 1-of-4 strobe
    fs_a = -1; fs_b = -1; le_a = -1; le_b = -1; fs_dbl = 0; le_dbl = 0; held_bad = 0;
    prev_s = obs_s;
    for (int i = 0; i < 2800; i++) begin
      step(1'b1, (i % 4) == 0);
      if (vga_s.frame_start) begin
        if (prev_s.frame_start) fs_dbl++;
        if (fs_a < 0) fs_a = i; else if (fs_b < 0) fs_b = i;
      end
      if (vga_s.line_end) begin
        if (prev_s.line_end) le_dbl++;
        if (le_a < 0) le_a = i; else if (le_b < 0) le_b = i;
      end
      a = obs_s; b = prev_s;
      a.frame_start = 1'b0; a.line_end = 1'b0;
      b.frame_start = 1'b0; b.line_end = 1'b0;
      if (((i % 4) != 0) && (a != b)) held_bad++;
      prev_s = obs_s;
    end
    chk_int("strobe_frame_period", fs_b - fs_a, 4 * S_HTOT * S_VTOT);
    chk_int("strobe_line_period", le_b - le_a, 4 * S_HTOT);
    chk_int("strobe_fs_one_clock", fs_dbl, 0);
    chk_int("strobe_le_one_clock", le_dbl, 0);
    chk_int("strobe_outputs_held", held_bad, 0);

    // mid-frame async reset, small instance at (row 4, col 8)
    k = 0;
    while (!(vga_s.row == 10'd4 && vga_s.col == 10'd8) && k < 400) begin
      step(1'b1, 1'b1);
      k++;
    end
    chk_int("s_reach_mid", int'(k < 400), 1);
    rst_s = 1'b0;
    #1;
    chk("s_async_reset", obs_s, rst_val(1'b0));
    repeat (3) step(1'b1, 1'b1);
    rst_s = 1'b1;
    step(1'b1, 1'b1);
    chk_int("s_restart_fs", int'(vga_s.frame_start), 1);

    // mid-line async reset, full instance at col 400
    k = 0;
    while (!(vga_f.col == 10'd400 && !vga_f.blank) && k < 1200) begin
      step(1'b1, 1'b1);
      k++;
    end
    chk_int("f_reach_mid", int'(k < 1200), 1);
    rst_f = 1'b0;
    #1;
    chk("f_async_reset", obs_f, rst_val(1'b1));
    repeat (3) step(1'b1, 1'b1);
    rst_f = 1'b1;
    step(1'b1, 1'b1);
    chk_int("f_restart_fs", int'(vga_f.frame_start), 1);
    chk_int("f_restart_col", int'(vga_f.col), 0);
    repeat (4) step(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
